mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum number of cycles to wait for ram_done before aborting an access.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 Port boot_lock, input, 1: when high, only port 0 (loader) may be granted.
REQ-005 Ports p0_cs/p1_cs, input, 1 each: request, level; held high until the matching ready.
REQ-006 Ports p0_we/p1_we and p0_oe/p1_oe, input, 1 each: write and read enables.
REQ-007 Ports p0_addr/p1_addr, input, 32 each: byte address.
REQ-008 Ports p0_wdata/p1_wdata, input, 32 each: write data.
REQ-009 Ports p0_size/p1_size, input, 2 each: data size, same encoding as ram data_size.
REQ-010 Ports p0_rdata/p1_rdata, output, 32 each: read data.
REQ-011 Ports p0_ready/p1_ready, output, 1 each: one-cycle completion pulse.
REQ-012 Ports p0_err/p1_err, output, 1 each: one-cycle pulse, coincident with ready, on timeout.
REQ-013 RAM-side outputs: ram_addr (32), ram_wdata (32), ram_cs (1), ram_we (1), ram_oe (1), ram_size (2).
REQ-014 RAM-side inputs: ram_rdata (32) and ram_done (1), where ram_done is a one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, GRANT0, GRANT1.
REQ-016 In IDLE, ram_cs/ram_we/ram_oe SHALL be 0, and the arbiter SHALL sample requests and choose the next state.
REQ-017 Arbitration SHALL be round-robin with one last-grant bit: on simultaneous requests, the port not granted last wins; after reset port 0 has priority.
REQ-018 With boot_lock=1, p1_cs SHALL be ignored in IDLE; an in-flight GRANT1 access SHALL complete normally.
REQ-019 Request latency: cs sampled high in IDLE at edge N -> GRANTx from edge N, ram_cs=1 in cycle N+1.
REQ-020 In GRANTx, ram_addr/wdata/we/oe/size SHALL be registered copies of port x's inputs, captured on the IDLE->GRANTx edge and held constant.
REQ-021 In GRANTx, ram_done=1 SHALL pulse px_ready combinationally in the same cycle, with px_rdata=ram_rdata; the FSM SHALL go to IDLE on the next edge.
REQ-022 px_rdata SHALL be 0 whenever px_ready=0; the other port's ready/err SHALL stay 0.
REQ-023 Minimum spacing between two grants SHALL be one IDLE cycle, which gives the requester time to drop or renew cs after ready.
REQ-024 A timeout counter (8 bits, width sized by TIMEOUT) SHALL clear on entry to GRANTx and increment each cycle without ram_done.
REQ-025 When the counter reaches TIMEOUT, the arbiter SHALL pulse px_ready and px_err with px_rdata=0, then go to IDLE.
REQ-026 If ram_done and the timeout occur in the same cycle, the access SHALL be treated as a normal completion with err=0.
REQ-027 If px_cs drops while GRANTx, the access SHALL still complete and ready SHALL still pulse; withdrawal is not supported.
REQ-028 Only one of p0_ready/p1_ready SHALL be high in any cycle.

Reset
REQ-029 While rst_n=0 at an edge: state=IDLE, last-grant=port 1 (so port 0 wins first), counter=0, all RAM-side outputs 0, all ready/err 0.
REQ-030 Reset asserted mid-access SHALL abandon the access; no ready pulse SHALL be produced for it.

Structure
REQ-031 The state encoding (IDLE, GRANT0, GRANT1) and the default TIMEOUT constant SHALL live in the shared ARMv4 definitions package/include.
REQ-032 The design SHALL be one module with no sub-modules; the timeout counter stays inline.

Verification
REQ-033 Single read: p1_cs=1, oe=1, addr=0x100; RAM returns 0xDEADBEEF with ram_done 3 cycles after ram_cs -> one p1_ready pulse with p1_rdata=0xDEADBEEF; ram_cs high for exactly 3 cycles.
REQ-034 Contention: p0_cs and p1_cs held high, fast RAM -> grants alternate P0, P1, P0, P1, ... with one IDLE cycle between each.
REQ-035 Boot lock: boot_lock=1 with both ports requesting -> only port 0 served; boot_lock drops to 0 -> port 1 granted next.
REQ-036 Timeout: RAM never asserts ram_done with TIMEOUT=255 -> p0_ready and p0_err pulse exactly 255 cycles after grant, followed by IDLE.
REQ-037 Coincidence: ram_done arrives on the timeout cycle -> ready=1, err=0, rdata valid.
REQ-038 Reset mid-access: rst_n=0 for one cycle during GRANT0 -> ram_cs=0 next cycle, no p0_ready pulse, and port 0 wins the first arbitration afterwards.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared arbiter state encoding, default timeout and counter sizing
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_e;

    // Cycles to wait for ram_done before an access is aborted with err.
    localparam int MEM_ARB_TIMEOUT_DEFAULT = 255;

    // Width of a counter that must be able to hold the value t.
    function automatic int cnt_width(input int t);
        return (t < 2) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - two requester ports plus the shared RAM bus
// Port side: pX_cs/we/oe/addr/wdata/size requests, pX_rdata/ready/err responses.
// RAM side : ram_addr/wdata/cs/we/oe/size towards the RAM, ram_rdata/ram_done back.
// slave  modport: the arbiter's view.
// master modport: the environment's view (requesters and RAM).
interface mem_arbiter_if;

    logic        p0_cs;
    logic        p0_we;
    logic        p0_oe;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic [1:0]  p0_size;
    logic [31:0] p0_rdata;
    logic        p0_ready;
    logic        p0_err;

    logic        p1_cs;
    logic        p1_we;
    logic        p1_oe;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic [1:0]  p1_size;
    logic [31:0] p1_rdata;
    logic        p1_ready;
    logic        p1_err;

    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_cs;
    logic        ram_we;
    logic        ram_oe;
    logic [1:0]  ram_size;
    logic [31:0] ram_rdata;
    logic        ram_done;

    modport slave (
        input  p0_cs, p0_we, p0_oe, p0_addr, p0_wdata, p0_size,
        output p0_rdata, p0_ready, p0_err,
        input  p1_cs, p1_we, p1_oe, p1_addr, p1_wdata, p1_size,
        output p1_rdata, p1_ready, p1_err,
        output ram_addr, ram_wdata, ram_cs, ram_we, ram_oe, ram_size,
        input  ram_rdata, ram_done
    );

    modport master (
        output p0_cs, p0_we, p0_oe, p0_addr, p0_wdata, p0_size,
        input  p0_rdata, p0_ready, p0_err,
        output p1_cs, p1_we, p1_oe, p1_addr, p1_wdata, p1_size,
        input  p1_rdata, p1_ready, p1_err,
        input  ram_addr, ram_wdata, ram_cs, ram_we, ram_oe, ram_size,
        output ram_rdata, ram_done
    );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-port RAM arbiter with boot lock and access timeout
// clk       : single clock, rising edge
// rst_n     : synchronous active-low reset
// boot_lock : when high only port 0 (loader) may win arbitration
// bus       : requester ports and RAM bus (slave modport of mem_arbiter_if)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = MEM_ARB_TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         boot_lock,
    mem_arbiter_if.slave bus
);

    localparam int CW = cnt_width(TIMEOUT);

    arb_state_e    state_q;
    logic          last_q;      // 1: port 1 was granted most recently
    logic [CW-1:0] cnt_q;

    logic [31:0]   ram_addr_q;
    logic [31:0]   ram_wdata_q;
    logic          ram_cs_q;
    logic          ram_we_q;
    logic          ram_oe_q;
    logic [1:0]    ram_size_q;

    logic req0;
    logic req1;
    logic pick1;
    logic granted;
    logic timeout;
    logic finish;
    logic to_err;

    assign req0    = bus.p0_cs;
    assign req1    = bus.p1_cs & ~boot_lock;
    // On contention the port that did not win last time goes next.
    assign pick1   = req1 & (~req0 | ~last_q);
    assign granted = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);
    assign timeout = granted && (cnt_q == CW'(TIMEOUT));
    assign finish  = granted && (bus.ram_done || timeout);
    // A ram_done landing on the timeout cycle wins: normal completion.
    assign to_err  = timeout && !bus.ram_done;

    assign bus.p0_ready = finish && (state_q == ST_GRANT0);
    assign bus.p1_ready = finish && (state_q == ST_GRANT1);
    assign bus.p0_err   = to_err && (state_q == ST_GRANT0);
    assign bus.p1_err   = to_err && (state_q == ST_GRANT1);
    assign bus.p0_rdata = (state_q == ST_GRANT0 && bus.ram_done) ? bus.ram_rdata : '0;
    assign bus.p1_rdata = (state_q == ST_GRANT1 && bus.ram_done) ? bus.ram_rdata : '0;

    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_cs    = ram_cs_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_oe    = ram_oe_q;
    assign bus.ram_size  = ram_size_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_cs_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_oe_q    <= 1'b0;
            ram_size_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        state_q     <= pick1 ? ST_GRANT1 : ST_GRANT0;
                        last_q      <= pick1;
                        cnt_q       <= '0;
                        ram_cs_q    <= 1'b1;
                        ram_addr_q  <= pick1 ? bus.p1_addr  : bus.p0_addr;
                        ram_wdata_q <= pick1 ? bus.p1_wdata : bus.p0_wdata;
                        ram_we_q    <= pick1 ? bus.p1_we    : bus.p0_we;
                        ram_oe_q    <= pick1 ? bus.p1_oe    : bus.p0_oe;
                        ram_size_q  <= pick1 ? bus.p1_size  : bus.p0_size;
                    end
                end
                ST_GRANT0, ST_GRANT1: begin
                    if (finish) begin
                        // Always pass through IDLE so the requester can drop cs.
                        state_q  <= ST_IDLE;
                        ram_cs_q <= 1'b0;
                        ram_we_q <= 1'b0;
                        ram_oe_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    ram_cs_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    ram_oe_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
        int          cs_len;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic boot_lock;

    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT(255)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .boot_lock (boot_lock),
        .bus       (bus)
    );

    logic [31:0] a0 = '0, a1 = '0, wd0 = '0, wd1 = '0;
    logic        we0 = 1'b0, we1 = 1'b0, oe0 = 1'b0, oe1 = 1'b0;
    logic [1:0]  sz0 = '0, sz1 = '0;

    assign bus.p0_addr  = a0;
    assign bus.p1_addr  = a1;
    assign bus.p0_wdata = wd0;
    assign bus.p1_wdata = wd1;
    assign bus.p0_we    = we0;
    assign bus.p1_we    = we1;
    assign bus.p0_oe    = oe0;
    assign bus.p1_oe    = oe1;
    assign bus.p0_size  = sz0;
    assign bus.p1_size  = sz1;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          p0_left  = 0;
    int          p1_left  = 0;
    int          ram_lat  = 0;     // ram_done on this ram_cs cycle (1-based); 0 = never
    logic [31:0] ram_data = '0;
    int          ram_cnt  = 0;
    int          cs_run   = 0;
    bit          mon_en   = 1'b0;
    logic        prev_ready = 1'b0;
    exp_t        sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic port, input logic [31:0] rdata, input logic err, input int len);
        exp_t e;
        e.port   = port;
        e.rdata  = rdata;
        e.err    = err;
        e.cs_len = len;
        sb.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    task automatic drain(input string tag, input int budget);
        int cyc = 0;
        while ((sb.size() != 0 || p0_left != 0 || p1_left != 0) && cyc < budget) begin
            step();
            cyc++;
        end
        check({tag, "_drained"}, 32'(sb.size() == 0 && p0_left == 0 && p1_left == 0), 32'd1);
        repeat (2) step();
    endtask

    // Requesters, RAM model and response monitor.
    always @(negedge clk) begin : env
        exp_t e;
        logic port;
        bus.p0_cs = (p0_left > 0);
        bus.p1_cs = (p1_left > 0);
        if (bus.ram_cs === 1'b1) begin
            bus.ram_done = (ram_lat != 0) && (ram_cnt == ram_lat - 1);
            ram_cnt++;
        end else begin
            bus.ram_done = 1'b0;
            ram_cnt      = 0;
        end
        bus.ram_rdata = bus.ram_done ? ram_data : 32'h5555_AAAA;
        #1;
        if (mon_en) begin
            if (bus.ram_cs === 1'b1) cs_run++;
            else                     cs_run = 0;
            check("one_ready", 32'(bus.p0_ready & bus.p1_ready), 32'd0);
            if (bus.p0_ready !== 1'b1) begin
                check("p0_rdata_quiet", bus.p0_rdata, 32'd0);
                check("p0_err_quiet", 32'(bus.p0_err), 32'd0);
            end
            if (bus.p1_ready !== 1'b1) begin
                check("p1_rdata_quiet", bus.p1_rdata, 32'd0);
                check("p1_err_quiet", 32'(bus.p1_err), 32'd0);
            end
            if (prev_ready) check("idle_gap", 32'(bus.ram_cs), 32'd0);
            prev_ready = (bus.p0_ready === 1'b1) || (bus.p1_ready === 1'b1);
            if (prev_ready) begin
                port = (bus.p1_ready === 1'b1);
                check("sb_pending", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("grant_port", 32'(port), 32'(e.port));
                    check("rdata", port ? bus.p1_rdata : bus.p0_rdata, e.rdata);
                    check("err", 32'(port ? bus.p1_err : bus.p0_err), 32'(e.err));
                    check("cs_len", cs_run, e.cs_len);
                    check("ram_addr", bus.ram_addr, port ? a1 : a0);
                    check("ram_wdata", bus.ram_wdata, port ? wd1 : wd0);
                    check("ram_we", 32'(bus.ram_we), 32'(port ? we1 : we0));
                    check("ram_oe", 32'(bus.ram_oe), 32'(port ? oe1 : oe0));
                    check("ram_size", 32'(bus.ram_size), 32'(port ? sz1 : sz0));
                end
                if (port) begin
                    if (p1_left > 0) p1_left--;
                end else begin
                    if (p0_left > 0) p0_left--;
                end
            end
        end
    end

    initial begin
        int cyc;
        rst_n     = 1'b0;
        boot_lock = 1'b0;
        repeat (3) step();
        check("rst_ram_cs", 32'(bus.ram_cs), 32'd0);
        check("rst_ram_we", 32'(bus.ram_we), 32'd0);
        check("rst_ram_oe", 32'(bus.ram_oe), 32'd0);
        check("rst_ram_addr", bus.ram_addr, 32'd0);
        check("rst_ready", 32'({bus.p0_ready, bus.p1_ready, bus.p0_err, bus.p1_err}), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step();

        // Single read on port 1, RAM answers on the third ram_cs cycle.
        a1 = 32'h0000_0100; oe1 = 1'b1; we1 = 1'b0; sz1 = 2'b10;
        ram_lat = 3; ram_data = 32'hDEAD_BEEF;
        push(1'b1, 32'hDEAD_BEEF, 1'b0, 3);
        p1_left = 1;
        drain("read", 50);

        // Contention with fast RAM: strict alternation starting at port 0.
        a0 = 32'h2000_0000; wd0 = 32'h0BAD_F00D; we0 = 1'b1; oe0 = 1'b0; sz0 = 2'b01;
        a1 = 32'h0000_0300; wd1 = 32'h7777_1111; we1 = 1'b0; oe1 = 1'b1; sz1 = 2'b00;
        ram_lat = 1; ram_data = 32'h1234_5678;
        for (int i = 0; i < 6; i++) push(1'(i % 2), 32'h1234_5678, 1'b0, 1);
        p0_left = 3;
        p1_left = 3;
        drain("contend", 100);

        // Boot lock keeps port 1 out until released.
        boot_lock = 1'b1;
        ram_lat = 2; ram_data = 32'hA5A5_0001;
        push(1'b0, 32'hA5A5_0001, 1'b0, 2);
        push(1'b0, 32'hA5A5_0001, 1'b0, 2);
        p0_left = 2;
        p1_left = 1;
        cyc = 0;
        while (p0_left != 0 && cyc < 60) begin
            step();
            cyc++;
        end
        check("boot_p0_served", 32'(p0_left), 32'd0);
        check("boot_p1_held", 32'(p1_left), 32'd1);
        push(1'b1, 32'hA5A5_0001, 1'b0, 2);
        boot_lock = 1'b0;
        drain("boot", 60);

        // RAM never answers: ready+err on the 256th ram_cs cycle, rdata 0.
        a0 = 32'h0000_0040; we0 = 1'b0; oe0 = 1'b1; sz0 = 2'b10;
        ram_lat = 0;
        push(1'b0, 32'd0, 1'b1, 256);
        p0_left = 1;
        drain("timeout", 400);

        // ram_done on the timeout cycle counts as a normal completion.
        ram_lat = 256; ram_data = 32'hCAFE_F00D;
        push(1'b0, 32'hCAFE_F00D, 1'b0, 256);
        p0_left = 1;
        drain("coincide", 400);

        // Reset in the middle of a port-0 access.
        ram_lat = 0;
        p0_left = 1;
        cyc = 0;
        while (bus.ram_cs !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        check("mid_granted", 32'(bus.ram_cs), 32'd1);
        repeat (3) step();
        rst_n = 1'b0;
        ram_lat = 2; ram_data = 32'h0C0F_FEE0;
        a1 = 32'h0000_0500; oe1 = 1'b1; we1 = 1'b0;
        push(1'b0, 32'h0C0F_FEE0, 1'b0, 2);
        push(1'b1, 32'h0C0F_FEE0, 1'b0, 2);
        p1_left = 1;
        step();
        check("mid_rst_cs", 32'(bus.ram_cs), 32'd0);
        check("mid_rst_ready", 32'(bus.p0_ready), 32'd0);
        check("mid_rst_p0_pending", 32'(p0_left), 32'd1);
        rst_n = 1'b1;
        drain("after_rst", 60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
